shared_tlb_req_arbiter: RTL and testbench

Sequences L1 TLB misses into the single shared TLB and page-table walker of the Sv32 MMU. Up to two requesters compete: the instruction TLB (2 entries) and the data TLB (2 entries). The block picks one miss by round-robin and holds it through the shared-TLB lookup and, on a shared-TLB miss, the PTW walk. It then returns a single done pulse to the requester that owns the transaction.

---
 rtl/shared_tlb_req_arbiter_pkg.sv | 22 ++
 rtl/tlb_rr_pick2.sv | 20 ++
 rtl/shared_tlb_req_arbiter.sv | 144 ++++++++++++++
 tb/tb_shared_tlb_req_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_tlb_req_arbiter_pkg.sv
// Shared MMU definitions for the L1-miss arbiter in front of the shared TLB / PTW.
// Provides the Sv32-derived VPN width, the arbiter state enum and requester ids.
package shared_tlb_req_arbiter_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned SV32_OFFSET_W  = 12;
    localparam int unsigned SV32_VPN_W     = XLEN - SV32_OFFSET_W;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_PTW_REQ  = 3'd3,
        ST_PTW_WAIT = 3'd4
    } arb_state_e;

    typedef enum logic {
        REQ_ITLB = 1'b0,
        REQ_DTLB = 1'b1
    } req_id_e;

endpackage

// File: rtl/tlb_rr_pick2.sv
// Two-way round-robin picker.
// Ports: valid[1:0] (bit 0 = ITLB, bit 1 = DTLB), last_grant (previous winner),
//        grant[1:0] one-hot winner (zero when nothing is valid).
module tlb_rr_pick2
    import shared_tlb_req_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_e    last_grant,
    output logic [1:0] grant
);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = (last_grant == REQ_DTLB) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/shared_tlb_req_arbiter.sv
// Sequences ITLB/DTLB misses into the single shared TLB and page-table walker.
// Ports:
//   clk_i, rst_ni (async, active-low), flush_i (kills the transaction in flight)
//   itlb_* / dtlb_*   : miss request handshake, VPN and one-cycle done pulse
//   err_o             : qualifies the done pulse with a PTW fault
//   stlb_*            : shared-TLB lookup request/response, stlb_vpn_o also feeds the PTW
//   is_instr_o        : owner of the current transaction is the ITLB
//   ptw_*             : walk request handshake and walk completion/fault
module shared_tlb_req_arbiter
    import shared_tlb_req_arbiter_pkg::*;
#(
    parameter int unsigned VPN_WIDTH = SV32_VPN_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 itlb_req_valid_i,
    output logic                 itlb_req_ready_o,
    input  logic [VPN_WIDTH-1:0] itlb_vpn_i,
    output logic                 itlb_done_o,
    input  logic                 dtlb_req_valid_i,
    output logic                 dtlb_req_ready_o,
    input  logic [VPN_WIDTH-1:0] dtlb_vpn_i,
    output logic                 dtlb_done_o,
    output logic                 err_o,
    output logic                 stlb_req_valid_o,
    input  logic                 stlb_req_ready_i,
    output logic [VPN_WIDTH-1:0] stlb_vpn_o,
    output logic                 is_instr_o,
    input  logic                 stlb_rsp_valid_i,
    input  logic                 stlb_rsp_hit_i,
    output logic                 ptw_req_valid_o,
    input  logic                 ptw_req_ready_i,
    input  logic                 ptw_done_i,
    input  logic                 ptw_err_i
);

    arb_state_e           state_q, state_d;
    logic                 kill_q, kill_d;
    req_id_e              last_grant_q;
    req_id_e              owner_q;
    logic [VPN_WIDTH-1:0] vpn_q;
    logic                 itlb_done_q, dtlb_done_q, err_q;
    logic                 stlb_req_valid_q, ptw_req_valid_q;
    logic                 done_d, err_d;
    logic [1:0]           grant;
    logic                 accept;

    tlb_rr_pick2 u_pick (
        .valid      ({dtlb_req_valid_i, itlb_req_valid_i}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Accept only from IDLE; a flush in IDLE blocks the handshake for that cycle.
    assign accept = (state_q == ST_IDLE) && !flush_i && (grant != 2'b00);

    // Ready is combinational by design; gated by rst_ni so every output reads 0 in reset.
    assign itlb_req_ready_o = rst_ni && accept && grant[0];
    assign dtlb_req_ready_o = rst_ni && accept && grant[1];

    // Next-state, done and kill decisions.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (flush_i)               state_d = ST_IDLE;
                else if (stlb_req_ready_i) state_d = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (stlb_rsp_valid_i) begin
                    if (stlb_rsp_hit_i) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PTW_REQ;
                    end
                end
            end
            ST_PTW_REQ: begin
                if (flush_i)              state_d = ST_IDLE;
                else if (ptw_req_ready_i) state_d = ST_PTW_WAIT;
            end
            ST_PTW_WAIT: begin
                // The walk cannot be aborted: a flush only suppresses its done pulse.
                if (ptw_done_i) begin
                    done_d  = !(kill_q || flush_i);
                    err_d   = !(kill_q || flush_i) && ptw_err_i;
                    kill_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, transaction registers and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= ST_IDLE;
            kill_q           <= 1'b0;
            last_grant_q     <= REQ_DTLB;
            owner_q          <= REQ_DTLB;
            vpn_q            <= '0;
            itlb_done_q      <= 1'b0;
            dtlb_done_q      <= 1'b0;
            err_q            <= 1'b0;
            stlb_req_valid_q <= 1'b0;
            ptw_req_valid_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            kill_q           <= kill_d;
            itlb_done_q      <= done_d && (owner_q == REQ_ITLB);
            dtlb_done_q      <= done_d && (owner_q == REQ_DTLB);
            err_q            <= err_d;
            stlb_req_valid_q <= (state_d == ST_LOOKUP);
            ptw_req_valid_q  <= (state_d == ST_PTW_REQ);
            if (accept) begin
                vpn_q        <= grant[0] ? itlb_vpn_i : dtlb_vpn_i;
                owner_q      <= grant[0] ? REQ_ITLB : REQ_DTLB;
                last_grant_q <= grant[0] ? REQ_ITLB : REQ_DTLB;
            end
        end
    end

    assign itlb_done_o      = itlb_done_q;
    assign dtlb_done_o      = dtlb_done_q;
    assign err_o            = err_q;
    assign stlb_req_valid_o = stlb_req_valid_q;
    assign ptw_req_valid_o  = ptw_req_valid_q;
    assign stlb_vpn_o       = vpn_q;
    assign is_instr_o       = (owner_q == REQ_ITLB);

endmodule

// File: tb/tb_shared_tlb_req_arbiter.sv
// Bench for shared_tlb_req_arbiter: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level model.
module tb_shared_tlb_req_arbiter;

    localparam int unsigned VW = 20;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          itlb_req_valid_i, itlb_req_ready_o, itlb_done_o;
    logic [VW-1:0] itlb_vpn_i;
    logic          dtlb_req_valid_i, dtlb_req_ready_o, dtlb_done_o;
    logic [VW-1:0] dtlb_vpn_i;
    logic          err_o;
    logic          stlb_req_valid_o, stlb_req_ready_i;
    logic [VW-1:0] stlb_vpn_o;
    logic          is_instr_o;
    logic          stlb_rsp_valid_i, stlb_rsp_hit_i;
    logic          ptw_req_valid_o, ptw_req_ready_i, ptw_done_i, ptw_err_i;

    always #5 clk = ~clk;

    shared_tlb_req_arbiter #(.VPN_WIDTH(VW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .itlb_req_valid_i (itlb_req_valid_i),
        .itlb_req_ready_o (itlb_req_ready_o),
        .itlb_vpn_i       (itlb_vpn_i),
        .itlb_done_o      (itlb_done_o),
        .dtlb_req_valid_i (dtlb_req_valid_i),
        .dtlb_req_ready_o (dtlb_req_ready_o),
        .dtlb_vpn_i       (dtlb_vpn_i),
        .dtlb_done_o      (dtlb_done_o),
        .err_o            (err_o),
        .stlb_req_valid_o (stlb_req_valid_o),
        .stlb_req_ready_i (stlb_req_ready_i),
        .stlb_vpn_o       (stlb_vpn_o),
        .is_instr_o       (is_instr_o),
        .stlb_rsp_valid_i (stlb_rsp_valid_i),
        .stlb_rsp_hit_i   (stlb_rsp_hit_i),
        .ptw_req_valid_o  (ptw_req_valid_o),
        .ptw_req_ready_i  (ptw_req_ready_i),
        .ptw_done_i       (ptw_done_i),
        .ptw_err_i        (ptw_err_i)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Stimulus variables (index 0 = ITLB, 1 = DTLB)
    logic          rst_v;
    logic          rv [2];
    logic [VW-1:0] rvpn [2];
    logic          srdy, rspv, rsph, prdy, pdone, perr, flsh;

    // Transaction-level model: one transaction in flight, progress flags
    bit            m_busy, m_looked, m_missed, m_walking, m_killed;
    int            m_owner, m_last;
    logic [VW-1:0] m_vpn;
    bit            m_isi;
    bit            m_done [2];
    bit            m_err;
    bit            waiting [2];

    task automatic model_reset();
        m_busy = 0; m_looked = 0; m_missed = 0; m_walking = 0; m_killed = 0;
        m_owner = 1; m_last = 1; m_vpn = '0; m_isi = 0;
        m_done[0] = 0; m_done[1] = 0; m_err = 0;
        waiting[0] = 0; waiting[1] = 0;
    endtask

    task automatic clear_drive();
        rv[0] = 0; rv[1] = 0; srdy = 0; rspv = 0; rsph = 0;
        prdy = 0; pdone = 0; perr = 0; flsh = 0;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic cycle();
        int pick;
        bit nd [2];
        bit ne;
        bit fin;
        bit fin_err;
        @(negedge clk);
        rst_ni           = rst_v;
        flush_i          = flsh;
        itlb_req_valid_i = rv[0];
        itlb_vpn_i       = rvpn[0];
        dtlb_req_valid_i = rv[1];
        dtlb_vpn_i       = rvpn[1];
        stlb_req_ready_i = srdy;
        stlb_rsp_valid_i = rspv;
        stlb_rsp_hit_i   = rsph;
        ptw_req_ready_i  = prdy;
        ptw_done_i       = pdone;
        ptw_err_i        = perr;
        if (!rst_v) model_reset();
        #1;
        pick = -1;
        if (rv[0] && rv[1]) pick = (m_last == 0) ? 1 : 0;
        else if (rv[0])     pick = 0;
        else if (rv[1])     pick = 1;

        chk("itlb_req_ready", int'(itlb_req_ready_o), int'(rst_v && !m_busy && !flsh && pick == 0));
        chk("dtlb_req_ready", int'(dtlb_req_ready_o), int'(rst_v && !m_busy && !flsh && pick == 1));
        chk("itlb_done", int'(itlb_done_o), int'(m_done[0]));
        chk("dtlb_done", int'(dtlb_done_o), int'(m_done[1]));
        chk("err", int'(err_o), int'(m_err));
        chk("stlb_req_valid", int'(stlb_req_valid_o), int'(m_busy && !m_looked));
        chk("ptw_req_valid", int'(ptw_req_valid_o), int'(m_busy && m_missed && !m_walking));
        chk("stlb_vpn", int'(stlb_vpn_o), int'(m_vpn));
        chk("is_instr", int'(is_instr_o), int'(m_isi));

        nd[0] = 0; nd[1] = 0; ne = 0; fin = 0; fin_err = 0;
        if (rst_v) begin
            if (!m_busy) begin
                if (!flsh && pick >= 0) begin
                    m_busy = 1; m_looked = 0; m_missed = 0; m_walking = 0; m_killed = 0;
                    m_owner = pick; m_last = pick; m_vpn = rvpn[pick]; m_isi = (pick == 0);
                    waiting[pick] = 1;
                    rv[pick] = 0;
                end
            end else if (!m_looked) begin
                if (flsh) m_busy = 0;
                else if (srdy) m_looked = 1;
            end else if (!m_missed) begin
                if (flsh) m_busy = 0;
                else if (rspv) begin
                    if (rsph) begin fin = 1; m_busy = 0; end
                    else m_missed = 1;
                end
            end else if (!m_walking) begin
                if (flsh) m_busy = 0;
                else if (prdy) m_walking = 1;
            end else begin
                if (pdone) begin
                    if (!m_killed && !flsh) begin fin = 1; fin_err = perr; end
                    m_busy = 0;
                end else if (flsh) begin
                    m_killed = 1;
                end
            end
            if (fin) begin
                nd[m_owner] = 1; ne = fin_err; waiting[m_owner] = 0;
            end
            if (flsh) begin waiting[0] = 0; waiting[1] = 0; end
        end
        m_done[0] = nd[0]; m_done[1] = nd[1]; m_err = ne;
    endtask

    task automatic do_reset();
        clear_drive();
        rst_v = 0;
        cycle();
        cycle();
        rst_v = 1;
    endtask

    initial begin
        rst_v = 0; rst_ni = 0;
        rvpn[0] = '0; rvpn[1] = '0;
        clear_drive();
        flush_i = 0; itlb_req_valid_i = 0; dtlb_req_valid_i = 0;
        itlb_vpn_i = '0; dtlb_vpn_i = '0; stlb_req_ready_i = 0;
        stlb_rsp_valid_i = 0; stlb_rsp_hit_i = 0;
        ptw_req_ready_i = 0; ptw_done_i = 0; ptw_err_i = 0;
        model_reset();

        // Reset state and ITLB-only hit at minimum latency
        do_reset();
        chk("reset_stlb_valid", int'(stlb_req_valid_o), 0);
        chk("reset_is_instr", int'(is_instr_o), 0);
        rv[0] = 1; rvpn[0] = 20'h12345; srdy = 1;
        cycle();
        chk("t1_accept", int'(itlb_req_ready_o), 1);
        cycle();
        chk("t1_lookup", int'(stlb_req_valid_o), 1);
        chk("t1_vpn", int'(stlb_vpn_o), 'h12345);
        rspv = 1; rsph = 1;
        cycle();
        rspv = 0;
        cycle();
        chk("t1_done_n3", int'(itlb_done_o), 1);
        chk("t1_err", int'(err_o), 0);
        chk("t1_no_dtlb_done", int'(dtlb_done_o), 0);
        cycle();
        chk("t1_done_single", int'(itlb_done_o), 0);

        // Ties alternate starting with the ITLB
        do_reset();
        srdy = 1; rsph = 1;
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (!rv[r]) begin rv[r] = 1; rvpn[r] = VW'($urandom); end
            end
            cycle();
            chk("tie_itlb_grant", int'(itlb_req_ready_o), int'(k % 2 == 0));
            chk("tie_dtlb_grant", int'(dtlb_req_ready_o), int'(k % 2 == 1));
            cycle();
            rspv = 1;
            cycle();
            rspv = 0;
        end
        cycle();

        // DTLB miss, walk with fault
        do_reset();
        rv[1] = 1; rvpn[1] = 20'hABCDE; srdy = 1;
        cycle();
        chk("t3_accept", int'(dtlb_req_ready_o), 1);
        cycle();
        rspv = 1; rsph = 0;
        cycle();
        rspv = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3_ptw_req", int'(ptw_req_valid_o), 1);
            chk("t3_is_instr", int'(is_instr_o), 0);
        end
        prdy = 1;
        cycle();
        prdy = 0;
        for (int i = 0; i < 9; i++) cycle();
        pdone = 1; perr = 1;
        cycle();
        pdone = 0; perr = 0;
        cycle();
        chk("t3_dtlb_done", int'(dtlb_done_o), 1);
        chk("t3_err", int'(err_o), 1);
        chk("t3_is_instr_end", int'(is_instr_o), 0);
        cycle();
        chk("t3_done_once", int'(dtlb_done_o), 0);

        // Flush coincident with a hit response
        do_reset();
        rv[0] = 1; rvpn[0] = 20'h00F0F; srdy = 1;
        cycle();
        cycle();
        flsh = 1; rspv = 1; rsph = 1; rv[1] = 1; rvpn[1] = 20'h5A5A5;
        cycle();
        flsh = 0; rspv = 0;
        cycle();
        chk("t4_no_done", int'(itlb_done_o), 0);
        chk("t4_new_accept", int'(dtlb_req_ready_o), 1);
        cycle();
        rspv = 1;
        cycle();
        rspv = 0;
        cycle();
        chk("t4_dtlb_done", int'(dtlb_done_o), 1);

        // Flush during the walk; done suppressed, no accept until the walk ends
        do_reset();
        rv[0] = 1; rvpn[0] = 20'h77777; srdy = 1;
        cycle();
        cycle();
        rspv = 1; rsph = 0;
        cycle();
        rspv = 0; prdy = 1;
        cycle();
        prdy = 0; flsh = 1; rv[1] = 1; rvpn[1] = 20'h11111;
        cycle();
        flsh = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t5_ready_blocked", int'(dtlb_req_ready_o), 0);
        end
        pdone = 1;
        cycle();
        chk("t5_ready_at_done", int'(dtlb_req_ready_o), 0);
        pdone = 0;
        cycle();
        chk("t5_no_done", int'(itlb_done_o), 0);
        chk("t5_accept_after", int'(dtlb_req_ready_o), 1);

        // Asynchronous reset while requesting a walk
        do_reset();
        rv[0] = 1; rv[1] = 1; rvpn[0] = 20'h22222; rvpn[1] = 20'h33333; srdy = 1;
        cycle();
        cycle();
        rspv = 1; rsph = 0;
        cycle();
        rspv = 0;
        cycle();
        chk("t6_in_ptw_req", int'(ptw_req_valid_o), 1);
        #2;
        rst_v = 0; rst_ni = 0;
        #1;
        chk("t6_rst_ptw_valid", int'(ptw_req_valid_o), 0);
        chk("t6_rst_stlb_valid", int'(stlb_req_valid_o), 0);
        chk("t6_rst_vpn", int'(stlb_vpn_o), 0);
        chk("t6_rst_is_instr", int'(is_instr_o), 0);
        chk("t6_rst_dtlb_ready", int'(dtlb_req_ready_o), 0);
        chk("t6_rst_itlb_done", int'(itlb_done_o), 0);
        chk("t6_rst_err", int'(err_o), 0);
        clear_drive();
        cycle();
        cycle();
        rst_v = 1; rv[0] = 1; rv[1] = 1; srdy = 1;
        cycle();
        chk("t6_tie_itlb", int'(itlb_req_ready_o), 1);
        chk("t6_tie_dtlb", int'(dtlb_req_ready_o), 0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!rv[r] && !waiting[r] && $urandom_range(3) == 0) begin
                    rv[r] = 1; rvpn[r] = VW'($urandom);
                end
            end
            srdy  = 1'($urandom_range(1));
            rspv  = ($urandom_range(2) == 0);
            rsph  = 1'($urandom_range(1));
            prdy  = 1'($urandom_range(1));
            pdone = ($urandom_range(5) == 0);
            perr  = 1'($urandom_range(1));
            flsh  = ($urandom_range(29) == 0);
            cycle();
        end
        clear_drive();
        for (int i = 0; i < 3; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
